// File: rtl/sram_frame_streamer_if.sv
// Bus bundle between the frame streamer and its environment: SRAM read port,
// byte stream toward the UART image-send wrapper, and status flags.
// master = streamer side, slave = SRAM / wrapper / controller side.
interface sram_frame_streamer_if;
    logic        i_start;
    logic [19:0] o_sram_addr;
    logic        o_sram_rd;
    logic [15:0] i_sram_rdata;
    logic        o_start_send;
    logic [7:0]  o_writedata;
    logic        o_writedata_valid;
    logic        i_byte_ack;
    logic        o_busy;
    logic        o_done;
    logic        o_underflow;

    modport master (
        input  i_start,
        input  i_sram_rdata,
        input  i_byte_ack,
        output o_sram_addr,
        output o_sram_rd,
        output o_start_send,
        output o_writedata,
        output o_writedata_valid,
        output o_busy,
        output o_done,
        output o_underflow
    );

    modport slave (
        output i_start,
        output i_sram_rdata,
        output i_byte_ack,
        input  o_sram_addr,
        input  o_sram_rd,
        input  o_start_send,
        input  o_writedata,
        input  o_writedata_valid,
        input  o_busy,
        input  o_done,
        input  o_underflow
    );
endinterface

// File: rtl/sram_frame_streamer.sv
// sram_frame_streamer: reads one RGB frame from SRAM (two words per pixel),
// serializes it as R,G,B bytes in raster order into a small FIFO and hands
// bytes out one per ack. Reads are credit-limited so the FIFO never overflows.
// Optional build macro STREAMER_TEST_PATTERN_EN: SRAM is not read; the bytes
// come from the pixel counters (R=h, G=v, B=h^v) with a one-cycle pipeline.
module sram_frame_streamer #(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter logic [19:0] BASE_ADDR  = 20'd0,
    parameter int          RD_LAT     = 2,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    sram_frame_streamer_if.master  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef STREAMER_TEST_PATTERN_EN
    localparam int LAT = 1;
`else
    localparam int LAT = RD_LAT;
`endif
    localparam logic [19:0] TOTAL_BYTES = 20'(3 * H_ACTIVE * V_ACTIVE);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t      state;
    logic [19:0] addr_cnt;
    logic [19:0] sram_addr_reg;
    logic        phase;          // 0: next read is word0 (R,G), 1: word1 (B)
    logic [15:0] h_cnt;
    logic [15:0] v_cnt;
    logic        rd_reg;
    logic        rd_type;
    logic        start_send_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        underflow_reg;

    logic [LAT-1:0] sr_valid;
    logic [LAT-1:0] sr_type;

    logic [7:0]  mem [FIFO_DEPTH];
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    cnt_t        fifo_count;
    cnt_t        remain;
    logic [7:0]  head_reg;
    logic [19:0] byte_cnt;

    logic [7:0]  inflight_bytes;
    logic [7:0]  need_bytes;
    logic        credit_ok;
    logic        issue;
    logic        last_pixel;
    logic        land_valid;
    logic        land_type;
    logic [15:0] land_data;
    logic [1:0]  push_cnt;
    logic [7:0]  push_b0;
    logic [7:0]  push_b1;
    logic        pop;

    // Bytes already committed but not yet in the FIFO: the strobe register
    // plus every stage of the latency shift register.
    always_comb begin
        inflight_bytes = 8'd0;
        if (rd_reg) begin
            inflight_bytes = rd_type ? 8'd1 : 8'd2;
        end
        for (int i = 0; i < LAT; i++) begin
            if (sr_valid[i]) begin
                inflight_bytes = inflight_bytes + (sr_type[i] ? 8'd1 : 8'd2);
            end
        end
    end

    assign need_bytes = phase ? 8'd1 : 8'd2;
    assign credit_ok  = (8'(fifo_count) + inflight_bytes + need_bytes) <= 8'(FIFO_DEPTH);
    assign issue      = (state == S_FETCH) && credit_ok;
    assign last_pixel = (h_cnt == 16'(H_ACTIVE - 1)) && (v_cnt == 16'(V_ACTIVE - 1));

    assign land_valid = sr_valid[LAT-1];
    assign land_type  = sr_type[LAT-1];
    assign push_cnt   = land_valid ? (land_type ? 2'd1 : 2'd2) : 2'd0;
    assign push_b0    = land_data[15:8];
    assign push_b1    = land_data[7:0];
    assign pop        = bus.i_byte_ack && (fifo_count != '0);
    assign remain     = fifo_count - cnt_t'(pop);

`ifdef STREAMER_TEST_PATTERN_EN
    logic [15:0] pat_word_reg;
    logic [15:0] pat_q;

    // Pattern source: capture the word at issue time, deliver it one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pat_word_reg <= 16'h0000;
            pat_q        <= 16'h0000;
        end else begin
            pat_q <= pat_word_reg;
            if (issue) begin
                pat_word_reg <= phase ? {h_cnt[7:0] ^ v_cnt[7:0], 8'h00}
                                      : {h_cnt[7:0], v_cnt[7:0]};
            end
        end
    end

    assign land_data     = pat_q;
    assign bus.o_sram_rd = 1'b0;
`else
    assign land_data     = bus.i_sram_rdata;
    assign bus.o_sram_rd = rd_reg;
`endif

    // Frame sequencer: launch pulse, credit-limited read issue, drain, done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= S_IDLE;
            addr_cnt       <= BASE_ADDR;
            sram_addr_reg  <= 20'd0;
            phase          <= 1'b0;
            h_cnt          <= 16'd0;
            v_cnt          <= 16'd0;
            rd_reg         <= 1'b0;
            rd_type        <= 1'b0;
            start_send_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            start_send_reg <= 1'b0;
            done_reg       <= 1'b0;
            rd_reg         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        state          <= S_LAUNCH;
                        start_send_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    addr_cnt <= BASE_ADDR;
                    phase    <= 1'b0;
                    h_cnt    <= 16'd0;
                    v_cnt    <= 16'd0;
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (issue) begin
                        rd_reg        <= 1'b1;
                        rd_type       <= phase;
                        sram_addr_reg <= addr_cnt;
                        addr_cnt      <= addr_cnt + 20'd1;
                        phase         <= ~phase;
                        if (phase) begin
                            if (last_pixel) begin
                                state <= S_DRAIN;
                            end else if (h_cnt == 16'(H_ACTIVE - 1)) begin
                                h_cnt <= 16'd0;
                                v_cnt <= v_cnt + 16'd1;
                            end else begin
                                h_cnt <= h_cnt + 16'd1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (byte_cnt == TOTAL_BYTES) begin
                        state    <= S_DONE;
                        done_reg <= 1'b1;
                        busy_reg <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-latency tracker: {valid,word_type} travels with each outstanding read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_valid <= '0;
            sr_type  <= '0;
        end else begin
            sr_valid[0] <= rd_reg;
            sr_type[0]  <= rd_type;
            for (int i = 1; i < LAT; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_type[i]  <= sr_type[i-1];
            end
        end
    end

    // FIFO storage: word0 lands as two entries in one cycle, word1 as one.
    always_ff @(posedge i_clk) begin
        if (push_cnt != 2'd0) begin
            mem[wr_ptr] <= push_b0;
        end
        if (push_cnt == 2'd2) begin
            mem[wr_ptr + ptr_t'(1)] <= push_b1;
        end
    end

    // FIFO pointers, registered head byte, pop counter and underflow flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            head_reg      <= 8'h00;
            byte_cnt      <= 20'd0;
            underflow_reg <= 1'b0;
        end else begin
            fifo_count <= fifo_count + cnt_t'(push_cnt) - cnt_t'(pop);
            wr_ptr     <= wr_ptr + ptr_t'(push_cnt);
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            // Head after this cycle: an older entry if one survives the pop,
            // else the first byte landing now, else hold the last value.
            if (remain != '0) begin
                head_reg <= mem[rd_ptr + ptr_t'(pop)];
            end else if (push_cnt != 2'd0) begin
                head_reg <= push_b0;
            end
            if (state == S_LAUNCH) begin
                byte_cnt <= 20'd0;
            end else if (pop) begin
                byte_cnt <= byte_cnt + 20'd1;
            end
            if (bus.i_byte_ack && (fifo_count == '0)) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign bus.o_sram_addr       = sram_addr_reg;
    assign bus.o_start_send      = start_send_reg;
    assign bus.o_writedata       = head_reg;
    assign bus.o_writedata_valid = (fifo_count != '0);
    assign bus.o_busy            = busy_reg;
    assign bus.o_done            = done_reg;
    assign bus.o_underflow       = underflow_reg;

endmodule

// File: tb/tb_sram_frame_streamer.sv
// Scoreboard bench for sram_frame_streamer on a 4x2 frame (24 bytes).
// Stimulus pushes the expected byte stream into a queue; a negedge monitor
// pops and compares on every accepted byte and checks every read address.
// Build with STREAMER_TEST_PATTERN_EN to check the pattern generator instead.
module tb_sram_frame_streamer;

    localparam int          H      = 4;
    localparam int          V      = 2;
    localparam logic [19:0] BASE   = 20'h00040;
    localparam int          RD_LAT = 2;
    localparam int          DEPTH  = 8;
    localparam int          TOTAL  = 3 * H * V;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_frame_streamer_if bus();

    sram_frame_streamer #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .BASE_ADDR  (BASE),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int done_cnt  = 0;
    int start_cnt = 0;
    int pop_cnt   = 0;
    int rd_idx    = 0;
    int rd_seen   = 0;
    int ack_mode  = 0;   // 0 none, 1 every 3rd cycle when valid, 2 every cycle, 3 every cycle when valid

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        int p;
        int k;
        logic [7:0] hb;
        logic [7:0] vb;
        p  = i / 3;
        k  = i % 3;
`ifdef STREAMER_TEST_PATTERN_EN
        hb = 8'(p % H);
        vb = 8'(p / H);
        case (k)
            0:       return hb;
            1:       return vb;
            default: return hb ^ vb;
        endcase
`else
        hb = 8'(p);
        vb = 8'h00;
        case (k)
            0:       return 8'h10 + hb + vb;
            1:       return 8'h20 + hb;
            default: return 8'h30 + hb;
        endcase
`endif
    endfunction

    function automatic logic [15:0] sram_word(input logic [19:0] a);
        logic [19:0] off;
        logic [7:0]  p;
        off = a - BASE;
        p   = off[8:1];
        return off[0] ? {8'h30 + p, 8'hEE} : {8'h10 + p, 8'h20 + p};
    endfunction

    // SRAM model: data appears RD_LAT cycles after the strobe, junk otherwise.
    logic [15:0] pipe [RD_LAT];
    always @(posedge clk) begin
        for (int k = RD_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= bus.o_sram_rd ? sram_word(bus.o_sram_addr) : 16'hDEAD;
    end
    assign bus.i_sram_rdata = pipe[RD_LAT-1];

    // Ack generator modelling the wrapper's ready.
    initial begin
        int cyc;
        cyc = 0;
        bus.i_byte_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ack_mode)
                1:       bus.i_byte_ack = ((cyc % 3) == 0) && bus.o_writedata_valid;
                2:       bus.i_byte_ack = 1'b1;
                3:       bus.i_byte_ack = bus.o_writedata_valid;
                default: bus.i_byte_ack = 1'b0;
            endcase
        end
    end

    // Monitor: byte scoreboard, read address sequence, pulse counters.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.i_byte_ack && bus.o_writedata_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL byte_extra: got %02h expected no byte", bus.o_writedata);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    $display("byte %0d: data=%02h exp=%02h", pop_cnt, bus.o_writedata, e);
                    chk("byte", 32'(bus.o_writedata), 32'(e));
                end
                pop_cnt++;
            end
            if (bus.o_sram_rd) begin
                chk("rd_addr", 32'(bus.o_sram_addr), 32'(BASE) + 32'(rd_idx));
                rd_idx++;
                rd_seen++;
            end
            if (bus.o_start_send) start_cnt++;
            if (bus.o_done) done_cnt++;
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_addr"},      32'(bus.o_sram_addr), 0);
        chk({tag, "_rd"},        32'(bus.o_sram_rd), 0);
        chk({tag, "_start_send"},32'(bus.o_start_send), 0);
        chk({tag, "_wdata"},     32'(bus.o_writedata), 0);
        chk({tag, "_wvalid"},    32'(bus.o_writedata_valid), 0);
        chk({tag, "_busy"},      32'(bus.o_busy), 0);
        chk({tag, "_done"},      32'(bus.o_done), 0);
        chk({tag, "_underflow"}, 32'(bus.o_underflow), 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit stall, input bit mid_start, input bit exp_uf);
        int d0;
        int s0;
        int guard;
        d0 = done_cnt;
        s0 = start_cnt;
        rd_idx = 0;
        for (int i = 0; i < TOTAL; i++) exp_q.push_back(exp_byte(i));
        ack_mode = stall ? 0 : mode;
        pulse_start();
        if (stall) begin
            repeat (40) @(posedge clk);
            @(negedge clk);
`ifndef STREAMER_TEST_PATTERN_EN
            chk("stall_reads", 32'(rd_idx), 5);
`endif
            chk("stall_valid", 32'(bus.o_writedata_valid), 1);
            ack_mode = mode;
        end
        if (mid_start) begin
            repeat (10) @(posedge clk);
            #1;
            chk("busy_mid", 32'(bus.o_busy), 1);
            bus.i_start = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            bus.i_start = 1'b0;
        end
        guard = 0;
        while (done_cnt == d0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        chk("done_seen", 32'(done_cnt != d0), 1);
        #1;
        ack_mode = 0;
        repeat (3) @(negedge clk);
        chk("done_once", 32'(done_cnt - d0), 1);
        chk("start_once", 32'(start_cnt - s0), 1);
        chk("busy_end", 32'(bus.o_busy), 0);
        chk("underflow", 32'(bus.o_underflow), 32'(exp_uf));
        chk("queue_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int d0;
        int p0;
        int guard;
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Normal frame, ack every third cycle.
        run_frame(1, 1'b0, 1'b0, 1'b0);
        // Acks held off: reads stall on credit, then nothing is lost.
        run_frame(3, 1'b1, 1'b0, 1'b0);
        // Second start request mid-frame is ignored.
        run_frame(3, 1'b0, 1'b1, 1'b0);
        // Ungated ack every cycle: empty acks flag underflow, stream intact.
        run_frame(2, 1'b0, 1'b0, 1'b1);

        // Abort a frame with reset after ten bytes, then restart cleanly.
        d0 = done_cnt;
        p0 = pop_cnt;
        rd_idx = 0;
        for (int i = 0; i < TOTAL; i++) exp_q.push_back(exp_byte(i));
        ack_mode = 3;
        pulse_start();
        guard = 0;
        while ((pop_cnt - p0) < 10 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        chk("abort_reached", 32'(pop_cnt - p0), 10);
        #1;
        rst_n    = 1'b0;
        ack_mode = 0;
        exp_q.delete();
        @(negedge clk);
        check_idle_outputs("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_done_abort", 32'(done_cnt), 32'(d0));
        run_frame(3, 1'b0, 1'b0, 1'b0);

`ifdef STREAMER_TEST_PATTERN_EN
        chk("rd_never", 32'(rd_seen), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
